// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive front end and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 2603;

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to RESET_VAL.
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: recovers frames at a fixed clocks-per-bit rate and presents
// bytes on a valid/ready holding register, flagging frame errors and overruns.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic w_rx_s;

  uart_rx_state_t r_state;
  uart_rx_state_t w_state_nxt;

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_sh;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_sample;
  logic w_byte_done;
  logic w_stop_bad;
  logic w_accept;

  bit_synchronizer #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .CLK  (CLK),
    .RST_N(RST_N),
    .i_d  (UART_RX),
    .o_q  (w_rx_s)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_idx_clr   = 1'b0;
    w_sample    = 1'b0;
    w_byte_done = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr   = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_clr = 1'b1;
          w_sample  = 1'b1;
          if (r_idx == IDX_LAST) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_clr   = 1'b1;
          w_byte_done = w_rx_s;
          w_stop_bad  = !w_rx_s;
          w_state_nxt = w_rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // Held-low line reports once; wait for idle before hunting for a start bit.
        w_cnt_clr = 1'b1;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sh  <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_idx_clr)     r_idx <= '0;
      else if (w_sample) r_idx <= r_idx + 1'b1;
      if (w_sample) r_sh <= {w_rx_s, r_sh[DATA_BITS-1:1]};
    end
  end

  assign w_accept = r_valid && rx_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_byte_done) begin
        // A full holding register only takes the new byte if it drains this cycle.
        if (!r_valid || w_accept) begin
          r_data  <= r_sh;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;

  localparam int CPB = 16;

  logic       CLK;
  logic       RST_N;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_cmp;
  int n_mis;
  int n_ferr_hi;
  int n_ovr_hi;
  int n_vld_rise;
  logic prev_vld;

  uart_byte_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .UART_RX  (UART_RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    n_ferr_hi  = 0;
    n_ovr_hi   = 0;
    n_vld_rise = 0;
    prev_vld   = 1'b0;
  end

  always @(negedge CLK) begin
    if (frame_err) n_ferr_hi++;
    if (overrun) n_ovr_hi++;
    if (rx_valid && !prev_vld) n_vld_rise++;
    prev_vld = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one frame; iteration e is applied before edge e and observed after it.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int n_edges,
                            input bit rdy_pulse,
                            output logic v153, output logic v154, output logic v155,
                            output logic ovr154, output logic ferr154,
                            output logic [7:0] d154, output logic [7:0] d155);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    v153 = 1'b0; v154 = 1'b0; v155 = 1'b0; ovr154 = 1'b0; ferr154 = 1'b0;
    d154 = 8'h00; d155 = 8'h00;
    for (int e = 0; e < n_edges; e++) begin
      UART_RX = fr[e / CPB];
      if (rdy_pulse && e == 154) rx_ready = 1'b1;
      if (rdy_pulse && e == 155) rx_ready = 1'b0;
      @(posedge CLK);
      #1;
      if (e == 153) v153 = rx_valid;
      if (e == 154) begin
        v154 = rx_valid; ovr154 = overrun; ferr154 = frame_err; d154 = rx_data;
      end
      if (e == 155) begin
        v155 = rx_valid; d155 = rx_data;
      end
    end
  endtask

  logic       v153, v154, v155, o154, f154;
  logic [7:0] d154, d155;
  int         base_f, base_o, base_v;

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    RST_N    = 1'b0;
    UART_RX  = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    RST_N = 1'b1;
    tick(5);

    // 0xA5 with rx_ready held high
    send_frame(8'hA5, 1'b1, 160, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    chk("a5_v153", v153, 1'b0);
    chk("a5_v154", v154, 1'b1);
    chk("a5_data", d154, 8'hA5);
    chk("a5_v155", v155, 1'b0);
    chk("a5_ferr", n_ferr_hi, 0);
    chk("a5_ovr", n_ovr_hi, 0);
    chk("a5_rises", n_vld_rise, 1);
    tick(20);

    // 3-cycle glitch on idle line
    base_v = n_vld_rise;
    base_f = n_ferr_hi;
    UART_RX = 1'b0;
    tick(3);
    UART_RX = 1'b1;
    tick(60);
    chk("gl_valid", rx_valid, 1'b0);
    chk("gl_rises", n_vld_rise - base_v, 0);
    chk("gl_ferr", n_ferr_hi - base_f, 0);

    // 0x3C with bad stop bit, line then held low, followed by 0x81
    base_v = n_vld_rise;
    base_f = n_ferr_hi;
    send_frame(8'h3C, 1'b0, 160, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    chk("fe_pulse154", f154, 1'b1);
    chk("fe_v154", v154, 1'b0);
    UART_RX = 1'b0;
    tick(100);
    chk("fe_count", n_ferr_hi - base_f, 1);
    chk("fe_rises", n_vld_rise - base_v, 0);
    UART_RX = 1'b1;
    tick(40);
    send_frame(8'h81, 1'b1, 160, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    chk("r81_v154", v154, 1'b1);
    chk("r81_data", d154, 8'h81);
    chk("r81_ferr", n_ferr_hi - base_f, 1);
    tick(20);

    // rx_ready low: 0x11 then 0x22 back-to-back, second byte overruns
    rx_ready = 1'b0;
    base_o = n_ovr_hi;
    send_frame(8'h11, 1'b1, 160, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    chk("ov1_v154", v154, 1'b1);
    chk("ov1_data", d154, 8'h11);
    send_frame(8'h22, 1'b1, 160, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    chk("ov2_pulse154", o154, 1'b1);
    chk("ov2_data", d155, 8'h11);
    chk("ov2_valid", v155, 1'b1);
    tick(5);
    chk("ov2_count", n_ovr_hi - base_o, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
    chk("ov_drain", rx_valid, 1'b0);

    // rx_ready pulsed at second completion: byte replaced, no overrun
    base_o = n_ovr_hi;
    send_frame(8'h11, 1'b1, 160, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    chk("rp1_data", d154, 8'h11);
    send_frame(8'h22, 1'b1, 160, 1'b1, v153, v154, v155, o154, f154, d154, d155);
    chk("rp2_v154", v154, 1'b1);
    chk("rp2_data", d154, 8'h22);
    chk("rp2_v155", v155, 1'b1);
    chk("rp2_ovr", o154, 1'b0);
    tick(5);
    chk("rp2_ovr_count", n_ovr_hi - base_o, 0);
    rx_ready = 1'b1;
    tick(2);

    // Reset during data bit 4 of 0xFF, then 0x5A
    base_f = n_ferr_hi;
    base_v = n_vld_rise;
    send_frame(8'hFF, 1'b1, 88, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    RST_N = 1'b0;
    #1;
    chk("mr_data", rx_data, 8'h00);
    chk("mr_valid", rx_valid, 1'b0);
    chk("mr_ferr", frame_err, 1'b0);
    chk("mr_ovr", overrun, 1'b0);
    tick(3);
    UART_RX = 1'b1;
    tick(2);
    RST_N = 1'b1;
    tick(200);
    chk("mr_no_valid", n_vld_rise - base_v, 0);
    chk("mr_no_ferr", n_ferr_hi - base_f, 0);
    send_frame(8'h5A, 1'b1, 160, 1'b0, v153, v154, v155, o154, f154, d154, d155);
    chk("r5a_v153", v153, 1'b0);
    chk("r5a_v154", v154, 1'b1);
    chk("r5a_data", d154, 8'h5A);
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial-to-parallel front end of the program loader: samples the asynchronous `UART_RX` line, recovers 8N1 frames at a fixed clocks-per-bit rate and presents each received byte on a valid/ready port. Downstream, the loader writes the bytes into instruction and data memory. Frame errors and overruns are flagged as single-cycle pulses; the block never stalls the line.

## Interface
- `CLKS_PER_BIT`, 2603, CLK cycles per UART bit period; must be ≥ 4.
- `DATA_BITS`, 8, payload bits per frame, LSB first.
- `CLK`  in  1  system clock, all logic on the rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `UART_RX`  in  1  raw serial line, idle high, asynchronous to CLK.
- `rx_data`  out  DATA_BITS  received byte; holds while `rx_valid` is high.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because the holding register was full.

## Operation
- `UART_RX` passes through a 2-flop synchronizer, both flops reset to 1; FSM uses only the synchronized value `rx_s`.
- `H = CLKS_PER_BIT/2` (integer division); `C = CLKS_PER_BIT`; one counter `cnt` of width `$clog2(C)`; bit index `idx`; shift register `sh`.
- IDLE: on `rx_s == 0` -> START, `cnt <= 0`.
- START: count; when `cnt == H-1`: if `rx_s == 1`, false start (glitch) -> IDLE, nothing reported; else `cnt <= 0`, `idx <= 0` -> DATA.
- DATA: when `cnt == C-1`: `sh <= {rx_s, sh[DATA_BITS-1:1]}` (LSB first), `cnt <= 0`, `idx++`; after the DATA_BITS-th sample -> STOP.
- STOP: when `cnt == C-1`: if `rx_s == 1`, byte complete -> IDLE; if 0, `frame_err` pulses, byte discarded -> BREAK.
- BREAK: wait for `rx_s == 1`, then -> IDLE. A held-low line therefore produces exactly one `frame_err`, not a retrigger loop.
- Holding register on byte complete:
  - `rx_valid == 0`: load `rx_data`, set `rx_valid`.
  - `rx_valid == 1` and accepted in the same cycle: load the new byte, `rx_valid` stays 1, no overrun.
  - `rx_valid == 1` and not accepted: keep the old byte, drop the new one, pulse `overrun`.
- `rx_valid` clears the cycle after `rx_valid && rx_ready` unless reloaded as above.
- `rx_ready` has no effect on the FSM; reception continues regardless.

## Timing
- Reset values: state IDLE, `cnt = 0`, `idx = 0`, `sh = 0`, `rx_data = 0`, `rx_valid = 0`, `frame_err = 0`, `overrun = 0`, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately, with no pulse. After release, a line still low is seen as a new start bit.
- Let edge 0 be the first CLK edge that samples `UART_RX` low.
  - `rx_s` is low after edge 1; START is entered at edge 2.
  - Start check at edge 2+H.
  - Data bit i is sampled at edge 2+H+(i+1)·C.
  - Stop check at edge 2+H+(DATA_BITS+1)·C.
  - `rx_valid` (or `frame_err`) is high in the cycle following that edge.
- Default latency: 2+1301+9·2603 = edge 24730.
- `frame_err` and `overrun` are high for exactly one cycle.
- Back-to-back frames: a start bit that begins right after the nominal stop-bit centre is caught, since IDLE is re-entered half a bit before the stop bit ends.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t`
  - `localparam int UART_CLKS_PER_BIT_DEFAULT = 2603`
  - This package is shared with the future `uart_byte_tx`.
- Sub-module `bit_synchronizer`: parameterized reset value, 2 flops, `CLK`/`RST_N`.

## Test plan
All scenarios use `CLKS_PER_BIT=16` (H=8), drive bits for 16 cycles each, and hold `rx_ready=1` unless stated.
- Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> `rx_data=0xA5`, `rx_valid` rises after edge 154, drops one cycle after acceptance, no pulses.
- 3-cycle low glitch on an idle line -> FSM returns to IDLE at the start check; no valid, no `frame_err`.
- Send 0x3C with the stop bit driven 0, then hold the line low 100 cycles -> exactly one `frame_err` pulse, no valid; a following 0x81 frame is received correctly.
- `rx_ready=0`, send 0x11 then 0x22 back-to-back -> `rx_data` stays 0x11, one `overrun` pulse at the second stop check.
- `rx_ready` pulsed exactly at the second byte's completion cycle -> `rx_data` becomes 0x22, `rx_valid` stays high, no overrun.
- Assert `RST_N` low during data bit 4 of 0xFF, release with the line idle -> all outputs at reset values; next frame 0x5A is received correctly.
